// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: FSM state encoding, arm length and index-width helper for the RO PUF evaluator
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_COUNT = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } puf_state_e;

    localparam int ARM_CYCLES = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_puf_eval_counter.sv
// ro_edge_counter: synchronises one raw oscillator, detects rising edges and counts them with saturation
//   clk, rst_n : system clock, synchronous active-low reset
//   ro         : raw asynchronous oscillator output (already muxed)
//   clr        : synchronous counter clear (synchroniser keeps running)
//   en         : count enable
//   cnt        : saturating edge count
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    // sr[1:0] is the 2-flop synchroniser, sr[2] the previous synchronised level
    logic [2:0] sr;
    logic       rise;

    assign rise = sr[1] & ~sr[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr <= {sr[1:0], ro};
            if (clr)
                cnt <= '0;
            else if (en && rise && cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_puf_eval.sv
// ro_puf_eval: ring-oscillator PUF evaluator producing RESP_BITS comparison bits per request
//   clk, rst_n        : system clock, synchronous active-low reset
//   ro_in / ro_en     : raw oscillator outputs / per-oscillator enables
//   start             : single-cycle evaluation request (honoured only when idle)
//   sel_a, sel_b      : base oscillator indices, bit i uses (sel+i) mod N_RO
//   window            : clk cycles counted per bit (0 behaves as 1)
//   margin            : stability threshold, used only with RO_PUF_MARGIN_EN
//   busy, done        : evaluation in progress / one-cycle completion pulse
//   response, unstable: result bits, valid from the done pulse until the next one
// Build option: define RO_PUF_MARGIN_EN to flag bits whose count difference is below margin.
module ro_puf_eval
    import ro_puf_pkg::*;
#(
    parameter int N_RO      = 16,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RO-1:0]          ro_in,
    output logic [N_RO-1:0]          ro_en,
    input  logic                     start,
    input  logic [idx_w(N_RO)-1:0]   sel_a,
    input  logic [idx_w(N_RO)-1:0]   sel_b,
    input  logic [WIN_W-1:0]         window,
    input  logic [CNT_W-1:0]         margin,
    output logic                     busy,
    output logic                     done,
    output logic [RESP_BITS-1:0]     response,
    output logic [RESP_BITS-1:0]     unstable
);
    localparam int SW = idx_w(N_RO);
    localparam int BW = idx_w(RESP_BITS);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] ARM   = ST_ARM;
    localparam logic [2:0] COUNT = ST_COUNT;
    localparam logic [2:0] CMP   = ST_CMP;
    localparam logic [2:0] DONE  = ST_DONE;

    logic [2:0]           state;
    logic [SW-1:0]        sel_a_q, sel_b_q, idx_a, idx_b;
    logic [WIN_W-1:0]     win_q, win_eff, tcnt;
    logic [BW-1:0]        bit_i;
    logic [CNT_W-1:0]     cnt_a, cnt_b;
    logic [RESP_BITS-1:0] shadow, resp_q;
    logic                 arm, counting;

    assign arm      = state == ARM;
    assign counting = state == COUNT;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign win_eff  = (win_q == '0) ? WIN_W'(1) : win_q;

    // indices only move when bit_i advances, which always re-enters ARM
    assign idx_a = SW'((int'(sel_a_q) + int'(bit_i)) % N_RO);
    assign idx_b = SW'((int'(sel_b_q) + int'(bit_i)) % N_RO);

    assign ro_en = (arm || counting) ? ((N_RO'(1) << idx_a) | (N_RO'(1) << idx_b)) : '0;

    // the shadow is presented directly in the done cycle, then held in resp_q
    assign response = done ? shadow : resp_q;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_in[idx_a]),
        .clr   (arm),
        .en    (counting),
        .cnt   (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_in[idx_b]),
        .clr   (arm),
        .en    (counting),
        .cnt   (cnt_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_a_q <= '0;
            sel_b_q <= '0;
            win_q   <= '0;
            tcnt    <= '0;
            bit_i   <= '0;
            shadow  <= '0;
            resp_q  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sel_a_q <= sel_a;
                    sel_b_q <= sel_b;
                    win_q   <= window;
                    bit_i   <= '0;
                    tcnt    <= '0;
                    state   <= ARM;
                end
                ARM: if (tcnt == WIN_W'(ARM_CYCLES - 1)) begin
                    tcnt  <= '0;
                    state <= COUNT;
                end else begin
                    tcnt <= tcnt + WIN_W'(1);
                end
                COUNT: if (tcnt == win_eff - WIN_W'(1)) begin
                    tcnt  <= '0;
                    state <= CMP;
                end else begin
                    tcnt <= tcnt + WIN_W'(1);
                end
                CMP: begin
                    shadow[bit_i] <= cnt_a > cnt_b;
                    if (bit_i == BW'(RESP_BITS - 1)) begin
                        state <= DONE;
                    end else begin
                        bit_i <= bit_i + BW'(1);
                        state <= ARM;
                    end
                end
                DONE: begin
                    resp_q <= shadow;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RO_PUF_MARGIN_EN
    logic [CNT_W-1:0]     margin_q, diff;
    logic [RESP_BITS-1:0] shadow_u, unst_q;

    assign diff     = (cnt_a > cnt_b) ? cnt_a - cnt_b : cnt_b - cnt_a;
    assign unstable = done ? shadow_u : unst_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            margin_q <= '0;
            shadow_u <= '0;
            unst_q   <= '0;
        end else begin
            if (state == IDLE && start)
                margin_q <= margin;
            if (state == CMP)
                shadow_u[bit_i] <= diff < margin_q;
            if (done)
                unst_q <= shadow_u;
        end
    end
`else
    logic unused_margin;
    assign unused_margin = ^margin;
    assign unstable      = '0;
`endif

endmodule

// File: tb/tb_ro_puf_eval.sv
// tb_ro_puf_eval: directed checks of ro_puf_eval in three parameterisations
module tb_ro_puf_eval;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ro_in;
    logic        st;
    logic [3:0]  sel_a, sel_b;
    logic [15:0] window, margin;
    int          dut;
    int          half [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] en_log [0:4095];

    logic        start1, start8, start4;
    logic [15:0] en1, en8, en4;
    logic        busy1, busy8, busy4, done1, done8, done4;
    logic [0:0]  resp1, unst1, resp4, unst4;
    logic [7:0]  resp8, unst8;

    logic        m_done, m_busy;
    logic [7:0]  m_resp, m_unst;
    logic [15:0] m_en;

    always #5 clk = ~clk;

    // oscillator model: channel k toggles every half[k] clk cycles, 0 = stopped
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 16; k++)
            ro_in[k] = (half[k] == 0) ? 1'b0 : 1'((cyc / half[k]) % 2);
    end

    assign start1 = st && dut == 1;
    assign start8 = st && dut == 8;
    assign start4 = st && dut == 4;

    ro_puf_eval #(.N_RO(16), .CNT_W(16), .WIN_W(16), .RESP_BITS(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(en1), .start(start1),
        .sel_a(sel_a), .sel_b(sel_b), .window(window), .margin(margin),
        .busy(busy1), .done(done1), .response(resp1), .unstable(unst1)
    );

    ro_puf_eval #(.N_RO(16), .CNT_W(16), .WIN_W(16), .RESP_BITS(8)) u_b8 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(en8), .start(start8),
        .sel_a(sel_a), .sel_b(sel_b), .window(window), .margin(margin),
        .busy(busy8), .done(done8), .response(resp8), .unstable(unst8)
    );

    ro_puf_eval #(.N_RO(16), .CNT_W(4), .WIN_W(16), .RESP_BITS(1)) u_c4 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(en4), .start(start4),
        .sel_a(sel_a), .sel_b(sel_b), .window(window), .margin(margin[3:0]),
        .busy(busy4), .done(done4), .response(resp4), .unstable(unst4)
    );

    always_comb begin
        m_done = done1;
        m_busy = busy1;
        m_resp = {7'b0, resp1};
        m_unst = {7'b0, unst1};
        m_en   = en1;
        if (dut == 8) begin
            m_done = done8;
            m_busy = busy8;
            m_resp = resp8;
            m_unst = unst8;
            m_en   = en8;
        end else if (dut == 4) begin
            m_done = done4;
            m_busy = busy4;
            m_resp = {7'b0, resp4};
            m_unst = {7'b0, unst4};
            m_en   = en4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_osc(input int ch_a, input int h_a, input int ch_b, input int h_b);
        for (int k = 0; k < 16; k++)
            half[k] = 0;
        half[ch_a] = h_a;
        half[ch_b] = h_b;
    endtask

    // starts an evaluation in the current cycle (cycle 0) and runs until done;
    // rs is a cycle at which a second start is pulsed while busy (-1 for none)
    task automatic run(input int d, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [15:0] w, input logic [15:0] m, input int rs,
                       output int lat, output bit busy_ok);
        dut     = d;
        sel_a   = sa;
        sel_b   = sb;
        window  = w;
        margin  = m;
        st      = 1'b1;
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            tick();
            lat++;
            st = (lat == rs);
            if (lat < 4096)
                en_log[lat] = m_en;
            if (!m_busy)
                busy_ok = 1'b0;
        end while (!m_done && lat < 4000);
        st = 1'b0;
    endtask

    int lat;
    bit bok;

    initial begin
        rst_n  = 1'b0;
        st     = 1'b0;
        dut    = 1;
        sel_a  = '0;
        sel_b  = '0;
        window = '0;
        margin = '0;
        for (int k = 0; k < 16; k++)
            half[k] = 0;
        repeat (3) tick();
        dut = 8;
        #1;
        check("rst_busy", 32'(m_busy), 0);
        check("rst_done", 32'(m_done), 0);
        check("rst_en", 32'(m_en), 0);
        check("rst_resp", 32'(m_resp), 0);
        rst_n = 1'b1;
        tick();

        // basic comparison: ch3 period 8 (12-13 edges) beats ch5 period 10 (10 edges)
        set_osc(3, 4, 5, 5);
        run(1, 4'd3, 4'd5, 16'd100, 16'd0, -1, lat, bok);
        check("b1_latency", 32'(lat), 105);
        check("b1_resp", 32'(m_resp), 1);
        check("b1_en_meas", 32'(en_log[10]), 32'h0028);
        check("b1_en_done", 32'(m_en), 0);
        check("b1_busy", 32'(bok), 1);
        tick();
        check("b1_done_pulse", 32'(m_done), 0);
        check("b1_idle", 32'(m_busy), 0);
        check("b1_resp_held", 32'(m_resp), 1);

        run(1, 4'd5, 4'd3, 16'd100, 16'd0, -1, lat, bok);
        check("swap_resp", 32'(m_resp), 0);
        tick();
        run(1, 4'd3, 4'd3, 16'd100, 16'd0, -1, lat, bok);
        check("same_latency", 32'(lat), 105);
        check("same_resp", 32'(m_resp), 0);
        tick();

        // window=0 behaves as a 1-cycle window
        run(1, 4'd3, 4'd5, 16'd0, 16'd0, -1, lat, bok);
        check("win0_latency", 32'(lat), 6);
        tick();

        // 8-bit evaluation with index wrap; fast channels {0,2,3,6,15} share one waveform
        for (int k = 0; k < 16; k++)
            half[k] = 0;
        half[0]  = 1;
        half[2]  = 1;
        half[3]  = 1;
        half[6]  = 1;
        half[15] = 1;
        run(8, 4'd15, 4'd0, 16'd20, 16'd0, -1, lat, bok);
        check("b8_latency", 32'(lat), 193);
        check("b8_resp", 32'(m_resp), 32'h92);
        check("b8_busy", 32'(bok), 1);
        check("b8_en_bit0", 32'(en_log[10]), 32'h8001);
        check("b8_en_bit1", 32'(en_log[30]), 32'h0003);
        tick();
        check("b8_resp_held", 32'(m_resp), 32'h92);

        // saturation: period 8 (~25 edges) vs period 4 (~50 edges) both clip at 15 -> tie
        set_osc(1, 2, 2, 4);
        run(4, 4'd2, 4'd1, 16'd200, 16'd0, -1, lat, bok);
        check("sat_latency", 32'(lat), 205);
        check("sat_cnt_a", 32'(u_c4.cnt_a), 15);
        check("sat_cnt_b", 32'(u_c4.cnt_b), 15);
        check("sat_tie_resp", 32'(m_resp), 0);
        tick();
        run(4, 4'd1, 4'd0, 16'd200, 16'd0, -1, lat, bok);
        check("sat_vs_zero", 32'(m_resp), 1);
        tick();

        // reset in the middle of COUNT aborts; a later start completes and a start while busy is ignored
        set_osc(3, 4, 5, 5);
        dut    = 1;
        sel_a  = 4'd3;
        sel_b  = 4'd5;
        window = 16'd100;
        st     = 1'b1;
        tick();
        st = 1'b0;
        repeat (20) tick();
        check("pre_rst_busy", 32'(m_busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(m_busy), 0);
        check("abort_done", 32'(m_done), 0);
        check("abort_en", 32'(m_en), 0);
        check("abort_resp", 32'(m_resp), 0);
        tick();
        tick();
        run(1, 4'd3, 4'd5, 16'd100, 16'd0, 50, lat, bok);
        check("restart_latency", 32'(lat), 105);
        check("restart_resp", 32'(m_resp), 1);
        tick();
        check("ignored_start", 32'(m_busy), 0);

        // exact counts: ch3 period 10 -> 12 edges, ch7 period 12 -> 10 edges in 120 cycles
        set_osc(3, 5, 7, 6);
        run(1, 4'd3, 4'd7, 16'd120, 16'd3, -1, lat, bok);
        check("margin_resp", 32'(m_resp), 1);
`ifdef RO_PUF_MARGIN_EN
        check("margin3_unst", 32'(m_unst), 1);
`else
        check("margin3_unst", 32'(m_unst), 0);
`endif
        tick();
        run(1, 4'd3, 4'd7, 16'd120, 16'd2, -1, lat, bok);
        check("margin2_unst", 32'(m_unst), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_puf_eval.md
RO_PUF_EVAL -- requirements
Module: ro_puf_eval

Interface
REQ-001 SHALL have parameter N_RO, default 16: number of ring-oscillator channels (>=2).
REQ-002 SHALL have parameter CNT_W, default 16: edge-counter width.
REQ-003 SHALL have parameter WIN_W, default 16: measurement-window length width.
REQ-004 SHALL have parameter RESP_BITS, default 8: response bits per evaluation.
REQ-005 SHALL have port clk, input, 1: single system clock.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port ro_in, input, N_RO: raw asynchronous oscillator outputs.
REQ-008 SHALL have port ro_en, output, N_RO: per-oscillator enable.
REQ-009 SHALL have port start, input, 1: single-cycle evaluation request.
REQ-010 SHALL have ports sel_a and sel_b, input, clog2(N_RO) each: base oscillator indices.
REQ-011 SHALL have port window, input, WIN_W: clk cycles counted per bit.
REQ-012 SHALL have port margin, input, CNT_W: stability threshold.
REQ-013 SHALL have ports busy (1), done (1), response (RESP_BITS) and unstable (RESP_BITS), all outputs.

Function
REQ-014 SHALL implement the FSM states IDLE, ARM, COUNT, CMP and DONE.
REQ-015 SHALL, in IDLE with start=1, latch sel_a, sel_b, window and margin, clear bit index i to 0, and go to ARM; start SHALL be ignored in any other state.
REQ-016 SHALL, for bit i, select oscillator A=(sel_a+i) mod N_RO and B=(sel_b+i) mod N_RO.
REQ-017 SHALL drive ro_en high only for A and B, and only during ARM and COUNT; ro_en SHALL be 0 otherwise.
REQ-018 SHALL hold ARM for exactly 3 cycles, clearing both counters to flush the synchronisers.
REQ-019 SHALL hold COUNT for exactly max(window,1) cycles; window=0 is treated as 1.
REQ-020 SHALL, in COUNT, increment each counter by one on every synchronised rising edge of its oscillator, saturating at 2^CNT_W-1 with no wrap.
REQ-021 SHALL, in CMP (1 cycle), set shadow bit i = (cntA > cntB), so a tie gives 0; then if i<RESP_BITS-1, increment i and go to ARM, else go to DONE.
REQ-022 SHALL, in DONE (1 cycle), copy the shadow into response and unstable, pulse done=1, and return to IDLE.
REQ-023 SHALL hold response and unstable stable between done pulses.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL, when sel_a==sel_b, still run the full sequence; all bits are then 0.
REQ-026 SHALL give a latency from the start cycle to the done cycle of RESP_BITS*(max(window,1)+4)+1 clk cycles.

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, go to IDLE from any state and abort any evaluation in progress.
REQ-028 SHALL, on reset, clear response, unstable, the shadow registers, the counters and i to 0, with busy=0, done=0 and ro_en=0.

Configuration
REQ-029 SHALL, when RO_PUF_MARGIN_EN is defined, set unstable[i] in CMP when |cntA-cntB| < margin.
REQ-030 SHALL, when RO_PUF_MARGIN_EN is undefined, keep unstable constant 0, ignore margin, and leave all other behaviour unchanged.

Structure
REQ-031 SHALL define in package ro_puf_pkg: the FSM state enum, the constant ARM_CYCLES=3, and an index-width helper function.
REQ-032 SHALL use one sub-module, ro_edge_counter: a 2-flop synchroniser, rising-edge detect and a saturating CNT_W counter with clear and enable inputs, instantiated twice (A and B).
REQ-033 SHALL place the A/B selection mux before the synchronisers; selection changes only on entry to ARM.

Verification
REQ-034 SHALL cover this case: RESP_BITS=1, window=100, ro_in[3] period 8 clk, ro_in[5] period 10 clk, sel_a=3, sel_b=5 -> response[0]=1, done at cycle 105, ro_en=0x0028 during measurement.
REQ-035 SHALL cover this case: the same stimulus with sel_a=5, sel_b=3 -> response[0]=0; with sel_a=sel_b=3 -> response=0.
REQ-036 SHALL cover this case: RESP_BITS=8, N_RO=16, sel_a=15, sel_b=0, window=20 -> index wrap (bit1 compares 0 vs 1), done exactly at cycle 193, busy high throughout.
REQ-037 SHALL cover this case: CNT_W=4, window=200, oscillator period 4 -> counter saturates at 15, and a tie against another saturated counter gives bit 0.
REQ-038 SHALL cover this case: rst_n=0 asserted mid-COUNT -> IDLE on the next edge, outputs 0; a start 2 cycles later completes normally; a start while busy is ignored.
REQ-039 SHALL cover this case: with RO_PUF_MARGIN_EN defined, margin=3 and counts 12 vs 10 -> response[0]=1, unstable[0]=1; without the macro -> unstable=0.
